// File: rtl/ghash_ctrl_if.sv
// Block-stream and tag handshake bundle for the GHASH sequencer.
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high. Once valid is raised it is held
// with stable payload until that edge. ready is a registered signal and
// never depends combinationally on valid.
interface ghash_ctrl_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_data;
  logic         blk_last;
  logic         tag_valid;
  logic         tag_ready;
  logic [127:0] tag;

  // Producer/consumer side: supplies blocks, takes the tag.
  modport master (
    output blk_valid, blk_data, blk_last, tag_ready,
    input  blk_ready, tag_valid, tag
  );

  // Controller side.
  modport slave (
    input  blk_valid, blk_data, blk_last, tag_ready,
    output blk_ready, tag_valid, tag
  );
endinterface

// File: rtl/ghash_ctrl.sv
// GHASH sequencer: holds H and the running accumulator, feeds one
// (acc ^ X_i, H) operand pair per accepted block to an external GF(2^128)
// multiplier, and presents the final accumulator as a tag.
module ghash_ctrl #(
  parameter int MUL_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [127:0] h_in,
  input  logic         h_load,
  output logic         h_valid,
  ghash_ctrl_if.slave  bus,
  output logic         busy,
  output logic [127:0] mul_x,
  output logic [127:0] mul_y,
  input  logic [127:0] mul_z,
  output logic [1:0]   dbg_state
);

  // Counter wide enough to hold MUL_LAT; at least one bit when combinational.
  localparam int CW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t         state;
  logic [127:0]   h_q;
  logic [127:0]   acc;
  logic           last_q;
  logic [CW-1:0]  cnt;
  logic           blk_ready_q;
  logic           tag_valid_q;
  logic           accept;

  assign bus.blk_ready = blk_ready_q;
  assign bus.tag_valid = tag_valid_q;
  assign bus.tag       = acc;
  assign dbg_state     = state;
  assign accept        = bus.blk_valid & blk_ready_q;

  // Controller FSM; handshake outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      h_q         <= '0;
      acc         <= '0;
      mul_x       <= '0;
      mul_y       <= '0;
      last_q      <= 1'b0;
      cnt         <= '0;
      h_valid     <= 1'b0;
      blk_ready_q <= 1'b0;
      tag_valid_q <= 1'b0;
      busy        <= 1'b0;
    end else if (clear && state != S_IDLE) begin
      // Abort: drop the message or pending tag, keep the key. Any product
      // still in the multiplier is simply never captured.
      acc         <= '0;
      tag_valid_q <= 1'b0;
      busy        <= 1'b0;
      blk_ready_q <= 1'b1;
      state       <= S_ACCEPT;
    end else begin
      case (state)
        S_IDLE: begin
          if (h_load) begin
            h_q         <= h_in;
            h_valid     <= 1'b1;
            blk_ready_q <= 1'b1;
            state       <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          if (accept) begin
            // The block is paired with the key as it stands before this edge;
            // a same-cycle h_load is dropped because the message is now busy.
            mul_x       <= acc ^ bus.blk_data;
            mul_y       <= h_q;
            last_q      <= bus.blk_last;
            busy        <= 1'b1;
            cnt         <= CW'(MUL_LAT);
            blk_ready_q <= 1'b0;
            state       <= S_WAIT;
          end else if (h_load && !busy) begin
            h_q <= h_in;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            acc <= mul_z;
            if (last_q) begin
              tag_valid_q <= 1'b1;
              state       <= S_DONE;
            end else begin
              blk_ready_q <= 1'b1;
              state       <= S_ACCEPT;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DONE: begin
          if (bus.tag_ready) begin
            acc         <= '0;
            busy        <= 1'b0;
            tag_valid_q <= 1'b0;
            blk_ready_q <= 1'b1;
            state       <= S_ACCEPT;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ghash_ctrl.sv
// Bench for ghash_ctrl: three instances (MUL_LAT = 1, 0, 3), each paired
// with a behavioural multiplier of matching latency, checked against a
// message-level GHASH reference.
module tb_ghash_ctrl;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         clear_a     [N];
  logic [127:0] h_in_a      [N];
  logic         h_load_a    [N];
  logic         h_valid_a   [N];
  logic         blk_valid_a [N];
  logic         blk_ready_a [N];
  logic [127:0] blk_data_a  [N];
  logic         blk_last_a  [N];
  logic         tag_valid_a [N];
  logic         tag_ready_a [N];
  logic [127:0] tag_a       [N];
  logic         busy_a      [N];
  logic [127:0] mul_x_a     [N];
  logic [127:0] mul_y_a     [N];
  logic [1:0]   dbg_a       [N];

  int vec_cnt = 0;
  int err_cnt = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // GF(2^128) product, polynomial basis (bit i = x^i), x^128 = x^7+x^2+x+1.
  function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] z;
    logic [127:0] v;
    z = '0;
    v = a;
    for (int i = 0; i < 128; i++) begin
      if (b[i]) z ^= v;
      v = v[127] ? ((v << 1) ^ 128'h87) : (v << 1);
    end
    return z;
  endfunction

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : ((s == 1) ? 0 : 3);
  endfunction

  // ---------------- DUTs + external multipliers ----------------
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    ghash_ctrl_if u_if ();
    logic [127:0] mul_z;

    assign u_if.blk_valid = blk_valid_a[g];
    assign u_if.blk_data  = blk_data_a[g];
    assign u_if.blk_last  = blk_last_a[g];
    assign u_if.tag_ready = tag_ready_a[g];
    assign blk_ready_a[g] = u_if.blk_ready;
    assign tag_valid_a[g] = u_if.tag_valid;
    assign tag_a[g]       = u_if.tag;

    ghash_ctrl #(.MUL_LAT(L)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear_a[g]),
      .h_in      (h_in_a[g]),
      .h_load    (h_load_a[g]),
      .h_valid   (h_valid_a[g]),
      .bus       (u_if),
      .busy      (busy_a[g]),
      .mul_x     (mul_x_a[g]),
      .mul_y     (mul_y_a[g]),
      .mul_z     (mul_z),
      .dbg_state (dbg_a[g])
    );

    if (L == 0) begin : g_comb
      assign mul_z = gf_mul(mul_x_a[g], mul_y_a[g]);
    end else begin : g_pipe
      logic [127:0] pipe [L];
      always @(posedge clk) begin
        pipe[0] <= gf_mul(mul_x_a[g], mul_y_a[g]);
        for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
      end
      assign mul_z = pipe[L-1];
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [127:0] ghash_ref(input logic [127:0] h, input logic [127:0] q[$]);
    logic [127:0] a;
    a = '0;
    foreach (q[i]) a = gf_mul(a ^ q[i], h);
    return a;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset(input int s);
    check("rst_h_valid", h_valid_a[s], 0);
    check("rst_blk_ready", blk_ready_a[s], 0);
    check("rst_tag_valid", tag_valid_a[s], 0);
    check("rst_busy", busy_a[s], 0);
    check("rst_tag", tag_a[s], 0);
    check("rst_mul_x", mul_x_a[s], 0);
    check("rst_mul_y", mul_y_a[s], 0);
  endtask

  task automatic load_h(input int s, input logic [127:0] h);
    h_in_a[s] = h;
    h_load_a[s] = 1'b1;
    cyc(1);
    h_load_a[s] = 1'b0;
  endtask

  task automatic send_block(input int s, input logic [127:0] d, input logic last, input int gap);
    int n;
    n = 0;
    cyc(gap);
    blk_valid_a[s] = 1'b1;
    blk_data_a[s]  = d;
    blk_last_a[s]  = last;
    while (blk_ready_a[s] !== 1'b1 && n < 100) begin
      cyc(1);
      n++;
    end
    check("blk_ready_bound", n < 100, 1);
    cyc(1);
    blk_valid_a[s] = 1'b0;
    blk_last_a[s]  = 1'b0;
    blk_data_a[s]  = rand128();
  endtask

  task automatic wait_tag(input int s, output int n);
    n = 0;
    while (tag_valid_a[s] !== 1'b1 && n < 100) begin
      cyc(1);
      n++;
    end
    check("tag_wait_bound", n < 100, 1);
  endtask

  task automatic take_tag(input int s, input int hold, output logic [127:0] t);
    int n;
    wait_tag(s, n);
    t = tag_a[s];
    for (int i = 0; i < hold; i++) begin
      cyc(1);
      check("hold_tag_stable", tag_a[s], t);
      check("hold_tag_valid", tag_valid_a[s], 1);
      check("hold_blk_ready", blk_ready_a[s], 0);
    end
    tag_ready_a[s] = 1'b1;
    cyc(1);
    tag_ready_a[s] = 1'b0;
    check("post_tag_valid", tag_valid_a[s], 0);
    check("post_busy", busy_a[s], 0);
    check("post_tag_zero", tag_a[s], 0);
    check("post_blk_ready", blk_ready_a[s], 1);
  endtask

  task automatic run_msg(input int s, input logic [127:0] h, input int nblk, input int hold);
    logic [127:0] q[$];
    logic [127:0] t;
    for (int i = 0; i < nblk; i++) q.push_back(rand128());
    for (int i = 0; i < nblk; i++) begin
      send_block(s, q[i], (i == nblk - 1), $urandom_range(0, 3));
      check("msg_busy", busy_a[s], 1);
    end
    take_tag(s, hold, t);
    check("ghash_tag", t, ghash_ref(h, q));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] h1, h2, h3, t;
    logic [127:0] q[$];
    int n;

    for (int s = 0; s < N; s++) begin
      clear_a[s] = 0; h_in_a[s] = '0; h_load_a[s] = 0;
      blk_valid_a[s] = 0; blk_data_a[s] = '0; blk_last_a[s] = 0; tag_ready_a[s] = 0;
    end

    // Power-up reset
    rst_n = 1'b0;
    cyc(2);
    for (int s = 0; s < N; s++) check_reset(s);
    rst_n = 1'b1;
    cyc(3);
    for (int s = 0; s < N; s++) check("no_key_blk_ready", blk_ready_a[s], 0);

    // Identity key: A5.. then 0F.. (last) gives AA..; latency L+1 per block
    for (int s = 0; s < N; s++) begin
      load_h(s, 128'h1);
      check("h_valid_after_load", h_valid_a[s], 1);
      check("blk_ready_after_load", blk_ready_a[s], 1);
      send_block(s, {16{8'hA5}}, 1'b0, 0);
      n = 0;
      while (blk_ready_a[s] !== 1'b1 && n < 50) begin
        cyc(1);
        n++;
      end
      check("blk_ready_return_lat", n, lat_of(s) + 1);
      send_block(s, {16{8'h0F}}, 1'b1, 0);
      wait_tag(s, n);
      check("tag_valid_lat", n, lat_of(s) + 1);
      take_tag(s, 0, t);
      check("identity_tag", t, {16{8'hAA}});
    end

    // Random keys, 1..8 block messages, random gaps and tag stalls
    for (int s = 0; s < N; s++) begin
      for (int m = 0; m < 4; m++) begin
        h1 = rand128();
        load_h(s, h1);
        run_msg(s, h1, $urandom_range(1, 8), $urandom_range(0, 3));
      end
    end

    // Tag backpressure for 10 cycles, then a fresh message starts from acc=0
    h1 = rand128();
    load_h(0, h1);
    run_msg(0, h1, 3, 10);
    run_msg(0, h1, 2, 0);

    // Key reload rules: ignored while busy, honoured when idle
    h1 = rand128();
    h2 = rand128();
    h3 = rand128();
    load_h(0, h1);
    q.delete();
    q.push_back(rand128());
    q.push_back(rand128());
    check("pre_same_cycle_ready", blk_ready_a[0], 1);
    blk_valid_a[0] = 1'b1; blk_data_a[0] = q[0]; blk_last_a[0] = 1'b0;
    h_in_a[0] = h2; h_load_a[0] = 1'b1;
    cyc(1);
    blk_valid_a[0] = 1'b0; h_load_a[0] = 1'b0;
    load_h(0, h3);                         // lands in WAIT
    n = 0;
    while (blk_ready_a[0] !== 1'b1 && n < 50) begin
      cyc(1);
      n++;
    end
    check("hload_mid_ready_bound", n < 50, 1);
    load_h(0, h3);                         // ACCEPT but message in progress
    send_block(0, q[1], 1'b1, 0);
    wait_tag(0, n);
    load_h(0, h2);                         // DONE, tag pending
    take_tag(0, 0, t);
    check("hload_busy_ignored", t, ghash_ref(h1, q));
    load_h(0, h2);                         // idle ACCEPT: takes effect
    run_msg(0, h2, 2, 0);

    // Clear during WAIT (longest wait instance)
    h1 = rand128();
    load_h(2, h1);
    send_block(2, rand128(), 1'b0, 0);
    check("clear_wait_state", dbg_a[2], 2);
    clear_a[2] = 1'b1;
    cyc(1);
    clear_a[2] = 1'b0;
    check("clear_wait_tag_valid", tag_valid_a[2], 0);
    check("clear_wait_busy", busy_a[2], 0);
    check("clear_wait_acc", tag_a[2], 0);
    check("clear_wait_blk_ready", blk_ready_a[2], 1);
    check("clear_wait_h_valid", h_valid_a[2], 1);
    cyc(5);
    run_msg(2, h1, 3, 1);

    // Clear while the tag is pending
    h1 = rand128();
    load_h(0, h1);
    send_block(0, rand128(), 1'b1, 0);
    wait_tag(0, n);
    check("clear_done_pre_valid", tag_valid_a[0], 1);
    clear_a[0] = 1'b1;
    cyc(1);
    clear_a[0] = 1'b0;
    check("clear_done_tag_valid", tag_valid_a[0], 0);
    check("clear_done_busy", busy_a[0], 0);
    check("clear_done_acc", tag_a[0], 0);
    run_msg(0, h1, 2, 0);

    // Asynchronous reset in the middle of a multiply
    send_block(2, rand128(), 1'b0, 0);
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < N; s++) check_reset(s);
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
    for (int s = 0; s < N; s++) begin
      check("post_rst_blk_ready", blk_ready_a[s], 0);
      check("post_rst_h_valid", h_valid_a[s], 0);
    end
    h1 = rand128();
    load_h(2, h1);
    run_msg(2, h1, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
